// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage of the unicycle RISC-V core.
package riscv_pkg;

    localparam int          XLEN_DEFAULT = 64;
    localparam logic [31:0] NOP_INSTR    = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [31:0]             instr;
        logic [XLEN_DEFAULT-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched words; a flush wins over any push or pop.
module fetch_buffer
    import riscv_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(BUF_DEPTH):0] count,
    output fetch_entry_t               head
);

    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_entry_t  mem [BUF_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_pop  = pop & (count != '0);
    assign do_push = push & ((count != DEPTH_C) | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches one word at a time from imem and feeds the decoder.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instruction,
    output logic [XLEN-1:0] InstrPC,
    output logic            InstrValid,
    input  logic            InstrReady,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPC,
    output logic            MisalignErr
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] last_pc;
    logic [XLEN-1:0] redirect_target;
    logic            discard;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    assign redirect_target = {RedirectPC[XLEN-1:2], 2'b00};
    assign imem_addr       = fetch_pc;

    assign InstrValid = (count != '0);
    assign pop        = InstrValid & InstrReady;
    // A response landing on a redirect edge belongs to the old stream and is dropped.
    assign push       = (state == WAIT) & imem_rvalid & ~discard & ~Redirect;
    assign count_next = Redirect ? '0 : count + CW'(push) - CW'(pop);

    assign push_data.instr = imem_rdata;
    assign push_data.pc    = XLEN_DEFAULT'(req_pc);

    assign Instruction = InstrValid ? head.instr : NOP_INSTR;
    assign InstrPC     = InstrValid ? XLEN'(head.pc) : last_pc;

    fetch_buffer #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (Redirect),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            req_pc      <= '0;
            last_pc     <= '0;
            discard     <= 1'b0;
            imem_req    <= 1'b0;
            MisalignErr <= 1'b0;
        end else begin
            MisalignErr <= Redirect & (RedirectPC[1:0] != 2'b00);
            if (InstrValid) last_pc <= XLEN'(head.pc);

            case (state)
                IDLE: begin
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (imem_gnt) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + XLEN'(4);
                        discard  <= Redirect;
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        discard <= 1'b0;
                        if (count_next < DEPTH_C) begin
                            state    <= REQ;
                            imem_req <= 1'b1;
                        end else begin
                            state <= HOLD;
                        end
                    end else if (Redirect) begin
                        discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (count_next < DEPTH_C) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                end
            endcase

            // A redirect overrides any sequential increment made above.
            if (Redirect) fetch_pc <= redirect_target;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory model feeds words, a monitor predicts the decoder side.
module tb_instr_fetch_unit;
    import riscv_pkg::*;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata, Instruction;
    logic [63:0] InstrPC, RedirectPC;
    logic        InstrValid, InstrReady, Redirect, MisalignErr;

    logic        w_req, w_valid, w_mis;
    logic [63:0] w_addr, w_pc;
    logic [31:0] w_instr;
    logic        w_gnt = 1'b1;
    logic        w_zero = 1'b0;
    logic [31:0] w_rdata = 32'h0;
    logic [63:0] w_rpc = 64'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.XLEN(64), .RESET_PC(64'h0), .BUF_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instruction(Instruction), .InstrPC(InstrPC), .InstrValid(InstrValid),
        .InstrReady(InstrReady), .Redirect(Redirect), .RedirectPC(RedirectPC),
        .MisalignErr(MisalignErr)
    );

    // Second instance only exercises the PC wrap from a top-of-memory reset vector.
    instr_fetch_unit #(.XLEN(64), .RESET_PC(WRAP_PC), .BUF_DEPTH(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_gnt(w_gnt), .imem_rvalid(w_zero), .imem_rdata(w_rdata),
        .Instruction(w_instr), .InstrPC(w_pc), .InstrValid(w_valid),
        .InstrReady(w_zero), .Redirect(w_zero), .RedirectPC(w_rpc),
        .MisalignErr(w_mis)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] addr);
        if (addr == 64'h0) return 32'h00A30533;
        if (addr == 64'h4) return 32'h40A30533;
        return addr[31:0] ^ 32'h1357_9BDF;
    endfunction

    // Memory model: one outstanding request, response 1..N cycles after the grant.
    bit          pending = 1'b0;
    logic [63:0] pend_addr;
    int          delay_left = 0;
    int          rv_min = 1;
    int          rv_max = 1;
    bit          gnt_random = 1'b0;
    bit          inject_rvalid = 1'b0;

    initial begin
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(posedge clk);
            #2;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
            if (inject_rvalid) begin
                imem_rvalid   = 1'b1;
                imem_rdata    = 32'hDEADBEEF;
                inject_rvalid = 1'b0;
            end else if (pending) begin
                if (delay_left <= 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                    pending     = 1'b0;
                end else begin
                    delay_left--;
                end
            end
            imem_gnt = 1'b0;
            if (imem_req && !pending) begin
                imem_gnt = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
                if (imem_gnt) begin
                    pending    = 1'b1;
                    pend_addr  = imem_addr;
                    delay_left = int'($urandom_range(rv_min, rv_max));
                end
            end
        end
    end

    // Scoreboard monitor: expected words enter when rvalid is driven, leave when the decoder takes them.
    fetch_entry_t exp_q[$];
    fetch_entry_t exp_e;
    logic [63:0]  model_pc = 64'h0;
    logic [63:0]  last_pc = 64'h0;
    logic [63:0]  out_addr = 64'h0;
    logic [63:0]  tgt;
    bit           has_out = 1'b0;
    bit           stale = 1'b0;
    bit           mis_exp = 1'b0;
    bit           pop_now;

    always @(negedge clk) begin
        if (!rst_n) begin
            checkOutput("rst_valid", 64'(InstrValid), 64'(0));
            checkOutput("rst_instr", 64'(Instruction), 64'(NOP_INSTR));
            checkOutput("rst_pc", InstrPC, 64'h0);
            checkOutput("rst_req", 64'(imem_req), 64'(0));
            checkOutput("rst_addr", imem_addr, 64'h0);
            checkOutput("rst_mis", 64'(MisalignErr), 64'(0));
            exp_q.delete();
            has_out  = 1'b0;
            stale    = 1'b0;
            model_pc = 64'h0;
            last_pc  = 64'h0;
            mis_exp  = 1'b0;
        end else begin
            tgt = {RedirectPC[63:2], 2'b00};
            checkOutput("valid", 64'(InstrValid), 64'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                checkOutput("instr", 64'(Instruction), 64'(exp_q[0].instr));
                checkOutput("pc", InstrPC, exp_q[0].pc);
                last_pc = exp_q[0].pc;
            end else begin
                checkOutput("nop", 64'(Instruction), 64'(NOP_INSTR));
                checkOutput("pc_hold", InstrPC, last_pc);
            end
            checkOutput("misalign", 64'(MisalignErr), 64'(mis_exp));
            if (imem_req) checkOutput("imem_addr", imem_addr, model_pc);
            mis_exp = Redirect && (RedirectPC[1:0] != 2'b00);

            pop_now = (exp_q.size() != 0) && InstrReady && !Redirect;
            if (Redirect) exp_q.delete();
            else if (pop_now) void'(exp_q.pop_front());

            if (imem_rvalid && has_out) begin
                if (!Redirect && !stale) begin
                    exp_e.instr = imem_rdata;
                    exp_e.pc    = out_addr;
                    exp_q.push_back(exp_e);
                end
                has_out = 1'b0;
                stale   = 1'b0;
            end
            if (Redirect && has_out) stale = 1'b1;

            if (imem_req && imem_gnt) begin
                has_out  = 1'b1;
                out_addr = model_pc;
                stale    = Redirect;
                model_pc = Redirect ? tgt : model_pc + 64'd4;
            end else if (Redirect) begin
                model_pc = tgt;
            end
        end
    end

    task automatic applyStimulus(input logic redir, input logic [63:0] target, input logic ready);
        Redirect   = redir;
        RedirectPC = target;
        InstrReady = ready;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_req(input string tag, input logic [63:0] addr, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (imem_req && imem_addr == addr) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput(tag, 64'(found), 64'(1));
    endtask

    task automatic wait_valid(input string tag, input logic [63:0] pc, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (InstrValid) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput({tag, "_seen"}, 64'(found), 64'(1));
        if (found) checkOutput(tag, InstrPC, pc);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 64'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("wrap_rst_addr", w_addr, WRAP_PC);

        // Streaming fetch from reset with an always-ready decoder.
        applyStimulus(1'b0, 64'h0, 1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("wrap_req", 64'(w_req), 64'(1));
        checkOutput("wrap_addr0", w_addr, WRAP_PC);
        @(posedge clk); #1;
        checkOutput("lat_e2", 64'(InstrValid), 64'(0));
        checkOutput("wrap_addr1", w_addr, 64'h0);
        @(posedge clk); #1;
        checkOutput("lat_e3", 64'(InstrValid), 64'(1));
        checkOutput("first_instr", 64'(Instruction), 64'h00A30533);
        checkOutput("first_pc", InstrPC, 64'h0);
        repeat (10) @(posedge clk);

        // Stalled decoder fills the buffer, then drains in order.
        #1 applyStimulus(1'b0, 64'h0, 1'b0);
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        checkOutput("hold_req", 64'(imem_req), 64'(0));
        checkOutput("hold_head_pc", InstrPC, 64'h0);
        applyStimulus(1'b0, 64'h0, 1'b1);
        wait_req("resume_addr8", 64'h8, 20);

        // Redirect with a full buffer, a ready decoder and a stray rvalid.
        applyStimulus(1'b0, 64'h0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("full_req", 64'(imem_req), 64'(0));
        checkOutput("full_valid", 64'(InstrValid), 64'(1));
        applyStimulus(1'b1, 64'h200, 1'b1);
        inject_rvalid = 1'b1;
        @(posedge clk); #1;
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("flush_valid", 64'(InstrValid), 64'(0));
        wait_valid("redir200_pc", 64'h200, 20);

        // Misaligned redirect target.
        @(posedge clk); #1;
        applyStimulus(1'b1, 64'h102, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("mis_pulse", 64'(MisalignErr), 64'(1));
        @(posedge clk); #1;
        checkOutput("mis_clear", 64'(MisalignErr), 64'(0));
        wait_valid("redir100_pc", 64'h100, 20);

        // Redirect while the request for 0x8 is outstanding.
        rv_min = 3;
        rv_max = 3;
        do_reset();
        wait_req("see_addr8", 64'h8, 40);
        @(posedge clk); #1;
        applyStimulus(1'b1, 64'h100, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 64'h0, 1'b1);
        checkOutput("wait_flush_valid", 64'(InstrValid), 64'(0));
        wait_valid("wait_redir_pc", 64'h100, 30);

        // Random grants, latencies, backpressure and redirects.
        gnt_random = 1'b1;
        rv_min = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            applyStimulus(($urandom_range(0, 24) == 0), 64'($urandom_range(0, 1023)),
                          1'($urandom_range(0, 1)));
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 64'h0, 1'b1);
        gnt_random = 1'b0;
        repeat (10) @(posedge clk);

        // Reset asserted while a response is in flight.
        rv_min = 2;
        rv_max = 2;
        #1 do_reset();
        wait_req("t6_first_req", 64'h0, 10);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checkOutput("async_valid", 64'(InstrValid), 64'(0));
        checkOutput("async_instr", 64'(Instruction), 64'(NOP_INSTR));
        checkOutput("async_req", 64'(imem_req), 64'(0));
        checkOutput("async_addr", imem_addr, 64'h0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_req("restart_addr0", 64'h0, 10);
        wait_valid("restart_pc", 64'h0, 20);
        repeat (20) @(posedge clk);
        #1;

        checkOutput("wrap_valid", 64'(w_valid), 64'(0));
        checkOutput("wrap_instr", 64'(w_instr), 64'(NOP_INSTR));
        checkOutput("wrap_pc", w_pc, 64'h0);
        checkOutput("wrap_mis", 64'(w_mis), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
